// File: rtl/common_types_pkg.sv
// Shared AHB-Lite encodings and timer register map used by the timer slave.
package common_types_pkg;

  typedef enum logic [1:0] {
    TransIdle   = 2'b00,
    TransBusy   = 2'b01,
    TransNonseq = 2'b10,
    TransSeq    = 2'b11
  } htrans_t;

  typedef enum logic {
    RespOkay  = 1'b0,
    RespError = 1'b1
  } hresp_t;

  typedef enum logic [2:0] {
    RegCtrl     = 3'd0,
    RegCount    = 3'd1,
    RegCompare  = 3'd2,
    RegStatus   = 3'd3,
    RegPrescale = 3'd4
  } timer_reg_e;

  localparam int unsigned CtrlEnBit         = 0;
  localparam int unsigned CtrlAutoReloadBit = 1;
  localparam int unsigned CtrlIrqEnBit      = 2;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  function automatic logic is_active(htrans_t t);
    return (t == TransNonseq) || (t == TransSeq);
  endfunction

endpackage

// File: rtl/ahb_timer_slave_if.sv
// AHB-Lite slave-side signal bundle as seen from the bus multiplexor.
interface ahb_timer_slave_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic [31:0] hrdata;
  logic        hresp;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
    input  hreadyout, hrdata, hresp
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
    output hreadyout, hrdata, hresp
  );
endinterface

// File: rtl/timer_prescaler.sv
// Free-running prescaler: one-cycle tick every PRESCALE+1 enabled cycles.
module timer_prescaler #(
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  input  logic                  clr_i,
  output logic                  tick_o
);

  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;

  always_comb begin
    tick_o = en_i && (pcnt_q == prescale_i);
    pcnt_d = pcnt_q + PRESCALE_W'(1);
    if (!en_i || clr_i || tick_o) pcnt_d = '0;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) pcnt_q <= '0;
    else       pcnt_q <= pcnt_d;
  end

endmodule

// File: rtl/ahb_timer_slave.sv
// AHB-Lite timer peripheral: COUNT/COMPARE/STATUS/PRESCALE registers, zero-wait OKAY,
// two-cycle ERROR for illegal accesses, level interrupt on compare match.
module ahb_timer_slave
  import common_types_pkg::*;
#(
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                     clk,
  input  logic                     nrst,
  ahb_timer_slave_if.slave         bus,
  output logic                     irq
);

  typedef enum logic [1:0] {StOkay, StErr1, StErr2} bus_state_e;

  bus_state_e            state_q;
  logic                  hreadyout_q;
  hresp_t                hresp_q;
  logic                  dp_valid_q, dp_write_q;
  timer_reg_e            dp_off_q;
  logic                  en_q, autoreload_q, irqen_q, match_q, irq_q;
  logic [31:0]           count_q, compare_q;
  logic [PRESCALE_W-1:0] prescale_q;

  htrans_t     trans;
  logic        accept, illegal, wr_en, tick, cnt_eq, match_d;
  logic [31:0] count_d, rdata;
  logic        unused_bus;

  assign trans   = htrans_t'(bus.htrans);
  assign accept  = bus.hsel && bus.hready && is_active(trans);
  assign illegal = (bus.hsize != HSIZE_WORD) || (bus.haddr[1:0] != 2'b00) ||
                   (bus.haddr[4:2] > 3'(RegPrescale));
  assign wr_en   = dp_valid_q && dp_write_q && bus.hready;
  assign unused_bus = ^{bus.hburst, bus.haddr[31:5]};

  // Address phase is only sampled when the bus is ready; ERROR transfers never set valid.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_off_q   <= RegCtrl;
    end else if (bus.hready) begin
      dp_valid_q <= accept && !illegal;
      dp_write_q <= bus.hwrite;
      dp_off_q   <= timer_reg_e'(bus.haddr[4:2]);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= StOkay;
      hreadyout_q <= 1'b1;
      hresp_q     <= RespOkay;
    end else begin
      unique case (state_q)
        StErr1: begin
          state_q     <= StErr2;
          hreadyout_q <= 1'b1;
          hresp_q     <= RespError;
        end
        StOkay, StErr2: begin
          if (accept && illegal) begin
            state_q     <= StErr1;
            hreadyout_q <= 1'b0;
            hresp_q     <= RespError;
          end else begin
            state_q     <= StOkay;
            hreadyout_q <= 1'b1;
            hresp_q     <= RespOkay;
          end
        end
        default: begin
          state_q     <= StOkay;
          hreadyout_q <= 1'b1;
          hresp_q     <= RespOkay;
        end
      endcase
    end
  end

  timer_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk        (clk),
    .nrst       (nrst),
    .en_i       (en_q),
    .prescale_i (prescale_q),
    .clr_i      (wr_en && (dp_off_q == RegPrescale)),
    .tick_o     (tick)
  );

  always_comb begin
    cnt_eq  = (count_q == compare_q);
    count_d = count_q;
    match_d = match_q;
    if (tick) count_d = (cnt_eq && autoreload_q) ? 32'd0 : count_q + 32'd1;
    if (wr_en && (dp_off_q == RegCount)) count_d = bus.hwdata;
    if (wr_en && (dp_off_q == RegStatus) && bus.hwdata[0]) match_d = 1'b0;
    // A match set in the same cycle as a W1C must survive the clear.
    if (tick && cnt_eq) match_d = 1'b1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      en_q         <= 1'b0;
      autoreload_q <= 1'b0;
      irqen_q      <= 1'b0;
      match_q      <= 1'b0;
      irq_q        <= 1'b0;
      count_q      <= '0;
      compare_q    <= '0;
      prescale_q   <= '0;
    end else begin
      count_q <= count_d;
      match_q <= match_d;
      irq_q   <= match_q && irqen_q;
      if (wr_en && (dp_off_q == RegCtrl)) begin
        en_q         <= bus.hwdata[CtrlEnBit];
        autoreload_q <= bus.hwdata[CtrlAutoReloadBit];
        irqen_q      <= bus.hwdata[CtrlIrqEnBit];
      end
      if (wr_en && (dp_off_q == RegCompare))  compare_q  <= bus.hwdata;
      if (wr_en && (dp_off_q == RegPrescale)) prescale_q <= bus.hwdata[PRESCALE_W-1:0];
    end
  end

  always_comb begin
    rdata = '0;
    if (dp_valid_q && !dp_write_q) begin
      case (dp_off_q)
        RegCtrl: begin
          rdata[CtrlEnBit]         = en_q;
          rdata[CtrlAutoReloadBit] = autoreload_q;
          rdata[CtrlIrqEnBit]      = irqen_q;
        end
        RegCount:    rdata = count_q;
        RegCompare:  rdata = compare_q;
        RegStatus:   rdata[0] = match_q;
        RegPrescale: rdata = 32'(prescale_q);
        default:     rdata = '0;
      endcase
    end
  end

  assign bus.hrdata    = rdata;
  assign bus.hreadyout = hreadyout_q;
  assign bus.hresp     = hresp_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_ahb_timer_slave.sv
// Directed bench for ahb_timer_slave: reset, bus timing, counting, errors, collisions.
module tb_ahb_timer_slave;
  import common_types_pkg::*;

  logic        clk;
  logic        nrst;
  logic        irq;
  logic [31:0] rd;
  int unsigned n_checks;
  int unsigned n_errors;

  ahb_timer_slave_if bus ();

  // Single slave: the multiplexor ready is this slave's ready.
  assign bus.hready = bus.hreadyout;

  ahb_timer_slave #(
    .PRESCALE_W (16)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus),
    .irq  (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.hsel   = 1'b0;
    bus.htrans = TransIdle;
    bus.hwrite = 1'b0;
    bus.haddr  = 32'h0;
    bus.hsize  = HSIZE_WORD;
  endtask

  task automatic drive_addr(input logic wr, input logic [31:0] a, input logic [2:0] sz);
    bus.hsel   = 1'b1;
    bus.htrans = TransNonseq;
    bus.hwrite = wr;
    bus.haddr  = a;
    bus.hsize  = sz;
  endtask

  task automatic write_reg(input logic [31:0] a, input logic [31:0] d);
    drive_addr(1'b1, a, HSIZE_WORD);
    cyc();
    drive_idle();
    bus.hwdata = d;
    cyc();
  endtask

  task automatic read_reg(input logic [31:0] a, output logic [31:0] d);
    drive_addr(1'b0, a, HSIZE_WORD);
    cyc();
    drive_idle();
    @(negedge clk);
    d = bus.hrdata;
    cyc();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    nrst       = 1'b0;
    bus.hburst = 3'b000;
    bus.hwdata = 32'h0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_hreadyout", bus.hreadyout, 32'd1);
    check_eq("rst_hresp", bus.hresp, 32'd0);
    check_eq("rst_hrdata", bus.hrdata, 32'd0);
    check_eq("rst_irq", irq, 32'd0);
    @(negedge clk) nrst = 1'b1;
    cyc();

    // Reset in the middle of a write data phase.
    write_reg(32'h08, 32'hAA);
    write_reg(32'h10, 32'h55);
    write_reg(32'h00, 32'h6);
    drive_addr(1'b1, 32'h04, HSIZE_WORD);
    cyc();
    drive_idle();
    bus.hwdata = 32'h1234;
    #2 nrst = 1'b0;
    #1;
    check_eq("midrst_hreadyout", bus.hreadyout, 32'd1);
    check_eq("midrst_hresp", bus.hresp, 32'd0);
    check_eq("midrst_irq", irq, 32'd0);
    @(negedge clk) nrst = 1'b1;
    cyc();
    for (int i = 0; i < 5; i++) begin
      read_reg(32'(i * 4), rd);
      check_eq($sformatf("rst_reg%0d", i), rd, 32'd0);
    end

    // Reset during the stalled first ERROR cycle.
    drive_addr(1'b0, 32'h14, HSIZE_WORD);
    cyc();
    drive_idle();
    @(negedge clk);
    check_eq("err1_pre_rst_rdy", bus.hreadyout, 32'd0);
    #1 nrst = 1'b0;
    #1;
    check_eq("err1_rst_rdy", bus.hreadyout, 32'd1);
    check_eq("err1_rst_resp", bus.hresp, 32'd0);
    @(negedge clk) nrst = 1'b1;
    cyc();

    // BUSY with hsel is a no-op.
    bus.hsel   = 1'b1;
    bus.htrans = TransBusy;
    bus.hwrite = 1'b1;
    bus.haddr  = 32'h04;
    cyc();
    drive_idle();
    bus.hwdata = 32'h99;
    @(negedge clk);
    check_eq("busy_resp", bus.hresp, 32'd0);
    cyc();
    read_reg(32'h04, rd);
    check_eq("busy_count", rd, 32'd0);

    // Back-to-back write then read of COMPARE.
    drive_addr(1'b1, 32'h08, HSIZE_WORD);
    cyc();
    drive_addr(1'b0, 32'h08, HSIZE_WORD);
    bus.hwdata = 32'hFF;
    @(negedge clk);
    check_eq("b2b_wr_rdy", bus.hreadyout, 32'd1);
    check_eq("b2b_wr_resp", bus.hresp, 32'd0);
    cyc();
    drive_idle();
    @(negedge clk);
    check_eq("b2b_rd_data", bus.hrdata, 32'hFF);
    check_eq("b2b_rd_rdy", bus.hreadyout, 32'd1);
    check_eq("b2b_rd_resp", bus.hresp, 32'd0);
    cyc();

    // Counting with PRESCALE=3: ticks in cycles 4, 8, 12 after enable.
    write_reg(32'h10, 32'd3);
    write_reg(32'h08, 32'd2);
    write_reg(32'h00, 32'h7);
    read_reg(32'h04, rd);
    check_eq("cnt_c2", rd, 32'd0);
    read_reg(32'h04, rd);
    check_eq("cnt_c4", rd, 32'd0);
    read_reg(32'h04, rd);
    check_eq("cnt_c6", rd, 32'd1);
    repeat (4) cyc();
    read_reg(32'h0C, rd);
    check_eq("match_c12", rd, 32'd0);
    @(negedge clk);
    check_eq("irq_lag", irq, 32'd0);
    read_reg(32'h04, rd);
    check_eq("cnt_reload", rd, 32'd0);
    check_eq("irq_set", irq, 32'd1);
    read_reg(32'h0C, rd);
    check_eq("match_set", rd, 32'd1);
    write_reg(32'h0C, 32'd1);
    cyc();
    check_eq("irq_clr", irq, 32'd0);
    write_reg(32'h00, 32'h0);
    read_reg(32'h04, rd);
    check_eq("cnt_stop", rd, 32'd2);
    read_reg(32'h0C, rd);
    check_eq("match_clr", rd, 32'd0);

    // Wrap without reload, PRESCALE=0.
    write_reg(32'h10, 32'd0);
    write_reg(32'h08, 32'd5);
    write_reg(32'h04, 32'hFFFF_FFFF);
    write_reg(32'h00, 32'h1);
    read_reg(32'h04, rd);
    check_eq("wrap_count", rd, 32'd0);
    read_reg(32'h0C, rd);
    check_eq("wrap_nomatch", rd, 32'd0);
    write_reg(32'h00, 32'h0);

    // ERROR responses: bad offset read, then halfword write accepted in ERR2.
    write_reg(32'h04, 32'h1234);
    drive_addr(1'b0, 32'h14, HSIZE_WORD);
    cyc();
    drive_idle();
    @(negedge clk);
    check_eq("err_rd_c1_rdy", bus.hreadyout, 32'd0);
    check_eq("err_rd_c1_resp", bus.hresp, 32'd1);
    cyc();
    drive_addr(1'b1, 32'h04, 3'b001);
    @(negedge clk);
    check_eq("err_rd_c2_rdy", bus.hreadyout, 32'd1);
    check_eq("err_rd_c2_resp", bus.hresp, 32'd1);
    cyc();
    drive_idle();
    bus.hwdata = 32'hDEAD;
    @(negedge clk);
    check_eq("err_hw_c1_rdy", bus.hreadyout, 32'd0);
    check_eq("err_hw_c1_resp", bus.hresp, 32'd1);
    cyc();
    @(negedge clk);
    check_eq("err_hw_c2_rdy", bus.hreadyout, 32'd1);
    check_eq("err_hw_c2_resp", bus.hresp, 32'd1);
    cyc();
    @(negedge clk);
    check_eq("err_done_resp", bus.hresp, 32'd0);
    cyc();
    read_reg(32'h04, rd);
    check_eq("err_count_kept", rd, 32'h1234);

    // Misaligned word write to COMPARE is rejected.
    drive_addr(1'b1, 32'h0A, HSIZE_WORD);
    cyc();
    drive_idle();
    bus.hwdata = 32'h77;
    @(negedge clk);
    check_eq("misalign_rdy", bus.hreadyout, 32'd0);
    cyc();
    @(negedge clk);
    check_eq("misalign_resp", bus.hresp, 32'd1);
    cyc();
    read_reg(32'h08, rd);
    check_eq("misalign_cmp_kept", rd, 32'd5);

    // Bus write to COUNT on a tick cycle wins; one more tick follows before the read.
    write_reg(32'h08, 32'h100);
    write_reg(32'h04, 32'd0);
    write_reg(32'h00, 32'h1);
    write_reg(32'h04, 32'h10);
    read_reg(32'h04, rd);
    check_eq("coll_count", rd, 32'h11);

    // W1C landing on the match cycle: COUNT=0x40 now, 0x41 during the W1C data phase.
    write_reg(32'h00, 32'h0);
    write_reg(32'h08, 32'h41);
    write_reg(32'h00, 32'h1);
    write_reg(32'h04, 32'h40);
    write_reg(32'h0C, 32'd1);
    read_reg(32'h0C, rd);
    check_eq("coll_w1c_set", rd, 32'd1);
    write_reg(32'h00, 32'h0);
    write_reg(32'h0C, 32'd1);
    read_reg(32'h0C, rd);
    check_eq("w1c_clear", rd, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
